// File: rtl/adder_arbiter_pkg.sv
// Shared types and constants for the round-robin shared-adder scheduler.
// IDW is the requester-index width and is never allowed below one bit.
package adder_arbiter_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between NREQ operand sources and the shared adder.
// The master side is the requesters plus the result consumer; the slave side is the adder.
interface adder_arbiter_if
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int IDW   = idw(NREQ)
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0][WIDTH-1:0] req_a;
  logic [NREQ-1:0][WIDTH-1:0] req_b;
  logic [NREQ-1:0]            req_acc;
  logic [NREQ-1:0]            req_ready;
  logic                       rsp_valid;
  logic [IDW-1:0]             rsp_id;
  logic [WIDTH-1:0]           rsp_sum;
  logic                       rsp_carry;
  logic                       rsp_ready;

  modport master (
    output req_valid, req_a, req_b, req_acc, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );

  modport slave (
    input  req_valid, req_a, req_b, req_acc, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );
endinterface

// File: rtl/adder_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the search starts one past last_grant and
// wraps, so the most recently served requester has lowest priority.
module rr_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = idw(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);
  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_grant) + i) % NREQ;
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
      end
    end
  end
endmodule

// File: rtl/adder_arbiter.sv
// One registered WIDTH-bit adder shared round-robin between NREQ requesters,
// with a per-requester accumulator; one tagged result in flight at a time.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int IDW   = idw(NREQ)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  adder_arbiter_if.slave bus,
  output logic           busy
);
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [IDW-1:0]   id;
  } op_t;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic             carry;
    logic [WIDTH-1:0] sum;
  } rsp_t;

  state_e                     state, state_nxt;
  logic [IDW-1:0]             last_grant, grant_idx;
  logic [NREQ-1:0]            grant, req_ready;
  logic                       accept;
  op_t                        op_q;
  rsp_t                       rsp_q;
  logic [NREQ-1:0][WIDTH-1:0] acc;
  logic [WIDTH:0]             sum_full;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .valid      (bus.req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Grant is always a valid requester, so offering ready is the accept.
  // rst_n gates ready so nothing is offered while reset is held.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: if (rst_n && ena && (|bus.req_valid)) begin
        req_ready = grant;
        accept    = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign sum_full = {1'b0, op_q.a} + {1'b0, op_q.b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      rsp_q      <= '0;
      acc        <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else begin
      if (accept) begin
        op_q.a     <= bus.req_a[grant_idx];
        op_q.b     <= bus.req_acc[grant_idx] ? acc[grant_idx] : bus.req_b[grant_idx];
        op_q.id    <= grant_idx;
        last_grant <= grant_idx;
      end
      // Plain add overwrites the accumulator too; 0+0 is the clear idiom.
      if (state == EXEC) begin
        rsp_q.id      <= op_q.id;
        rsp_q.carry   <= sum_full[WIDTH];
        rsp_q.sum     <= sum_full[WIDTH-1:0];
        acc[op_q.id]  <= sum_full[WIDTH-1:0];
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = rsp_q.id;
  assign bus.rsp_sum   = rsp_q.sum;
  assign bus.rsp_carry = rsp_q.carry;
  assign busy          = (state != IDLE);
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: reset, add/overflow, fairness, ena gating,
// accumulate, backpressure and mid-op reset, all against hand-computed values.
module tb_adder_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  adder_arbiter_if #(.WIDTH(8), .NREQ(2), .IDW(1)) bus ();

  adder_arbiter #(.WIDTH(8), .NREQ(2), .IDW(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request, waits (bounded) for the grant, then checks the
  // full accept -> EXEC -> RESP -> IDLE sequence with rsp_ready held high.
  task automatic do_op(input string tag, input logic [1:0] v, input logic [1:0] accm,
                       input logic [7:0] a0, input logic [7:0] b0,
                       input logic [7:0] a1, input logic [7:0] b1,
                       input int exp_id, input logic [7:0] exp_sum, input logic exp_c);
    int n;
    bus.req_valid = v;
    bus.req_acc   = accm;
    bus.req_a[0]  = a0;  bus.req_b[0] = b0;
    bus.req_a[1]  = a1;  bus.req_b[1] = b1;
    bus.rsp_ready = 1'b1;
    #1;
    n = 0;
    while (bus.req_ready == 2'b00 && n < 10) begin
      tick();
      n++;
    end
    if (bus.req_ready == 2'b00) begin
      chk({tag, "_grant_timeout"}, 32'd0, 32'd1);
      bus.req_valid = 2'b00;
      return;
    end
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'(2'b01 << exp_id));
    tick();
    bus.req_valid = 2'b00;
    #1;
    chk({tag, "_exec_busy"}, 32'(busy), 32'd1);
    chk({tag, "_exec_novalid"}, 32'(bus.rsp_valid), 32'd0);
    tick();
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "_id"}, 32'(bus.rsp_id), 32'(exp_id));
    chk({tag, "_sum"}, 32'(bus.rsp_sum), 32'(exp_sum));
    chk({tag, "_carry"}, 32'(bus.rsp_carry), 32'(exp_c));
    tick();
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset with random inputs: every output must read zero.
    rst_n = 1'b0;
    ena   = 1'b1;
    bus.req_valid = 2'($urandom_range(1, 3));
    bus.req_acc   = 2'($urandom);
    bus.req_a     = 16'($urandom);
    bus.req_b     = 16'($urandom);
    bus.rsp_ready = 1'($urandom);
    repeat (3) tick();
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_sum", 32'(bus.rsp_sum), 32'd0);
    chk("rst_carry", 32'(bus.rsp_carry), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    bus.req_valid = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();

    do_op("add",  2'b01, 2'b00, 8'h12, 8'h34, 8'h00, 8'h00, 0, 8'h46, 1'b0);
    do_op("ovf",  2'b10, 2'b00, 8'h00, 8'h00, 8'hFF, 8'h02, 1, 8'h01, 1'b1);

    // Both requesting: strict alternation starting with requester 0.
    do_op("rr0",  2'b11, 2'b00, 8'h01, 8'h02, 8'h05, 8'h06, 0, 8'h03, 1'b0);
    do_op("rr1",  2'b11, 2'b00, 8'h01, 8'h02, 8'h05, 8'h06, 1, 8'h0B, 1'b0);
    do_op("rr2",  2'b11, 2'b00, 8'h01, 8'h02, 8'h05, 8'h06, 0, 8'h03, 1'b0);
    do_op("rr3",  2'b11, 2'b00, 8'h01, 8'h02, 8'h05, 8'h06, 1, 8'h0B, 1'b0);

    ena = 1'b0;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ena_off_ready", 32'(bus.req_ready), 32'd0);
      chk("ena_off_busy", 32'(busy), 32'd0);
    end
    ena = 1'b1;

    do_op("clr0", 2'b01, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 1'b0);
    do_op("clr1", 2'b10, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8'h00, 1'b0);
    do_op("acc1", 2'b10, 2'b10, 8'h00, 8'h00, 8'h10, 8'hAA, 1, 8'h10, 1'b0);
    do_op("acc2", 2'b10, 2'b10, 8'h00, 8'h00, 8'h10, 8'hAA, 1, 8'h20, 1'b0);
    do_op("acc3", 2'b10, 2'b10, 8'h00, 8'h00, 8'h10, 8'hAA, 1, 8'h30, 1'b0);
    do_op("acc0", 2'b01, 2'b01, 8'h01, 8'h77, 8'h00, 8'h00, 0, 8'h01, 1'b0);

    // Backpressure: hold RESP five cycles while requester 1 waits.
    bus.req_valid = 2'b01;
    bus.req_acc   = 2'b00;
    bus.req_a[0]  = 8'h20; bus.req_b[0] = 8'h22;
    bus.req_a[1]  = 8'h03; bus.req_b[1] = 8'h04;
    bus.rsp_ready = 1'b0;
    #1;
    chk("bp_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 2'b10;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_sum", 32'(bus.rsp_sum), 32'h42);
      chk("bp_id", 32'(bus.rsp_id), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_hold_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.req_ready), 32'd0);
    tick();
    chk("bp_next_ready", 32'(bus.req_ready), 32'd2);
    do_op("bp_next", 2'b10, 2'b00, 8'h20, 8'h22, 8'h03, 8'h04, 1, 8'h07, 1'b0);

    // Reset mid-EXEC: no response, and accumulators come back cleared.
    bus.req_valid = 2'b10;
    bus.req_acc   = 2'b10;
    bus.req_a[1]  = 8'h09;
    tick();
    bus.req_valid = 2'b00;
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_valid", 32'(bus.rsp_valid), 32'd0);
    end
    do_op("post_acc", 2'b10, 2'b10, 8'h00, 8'h00, 8'h05, 8'hEE, 1, 8'h05, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin scheduler that shares one registered WIDTH-bit adder between NREQ requesters over valid/ready handshakes. It supports plain add (a+b) and per-requester accumulate (acc+a), and returns one tagged result at a time. It sits between the pin-level operand sources and the output mux inside the project top, replacing the free-running combinational ui_in + uio_in sum with a sequenced, shared datapath.

## Interface
Parameters:
- WIDTH, 8, operand/result width
- NREQ, 2, number of requesters (≥2); IDW = max(1, clog2(NREQ))

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- ena  in  1  grant enable; 0 blocks new grants, in-flight op still completes
- req_valid  in  NREQ  request pending, bit i = requester i
- req_a  in  NREQ*WIDTH  operand A, slice i = requester i
- req_b  in  NREQ*WIDTH  operand B (ignored in accumulate mode)
- req_acc  in  NREQ  1 = accumulate mode (acc[i] + a)
- req_ready  out  NREQ  one-hot accept strobe
- rsp_valid  out  1  result available
- rsp_id  out  IDW  requester index of result
- rsp_sum  out  WIDTH  result, modulo 2^WIDTH
- rsp_carry  out  1  carry out of bit WIDTH-1
- rsp_ready  in  1  consumer accepts result
- busy  out  1  state != IDLE

## Operation
- FSM states IDLE, EXEC, RESP; reset state IDLE.
- IDLE: if ena and any req_valid, rr_arbiter picks grant g; req_ready[g]=1 that cycle only. Accept = req_valid[g] & req_ready[g]. On accept, latch a, b/acc[g], mode and g, update last_grant=g, go to EXEC. Otherwise stay.
- req_ready is combinational from state, ena, req_valid and pointer; it is 0 in EXEC/RESP. Requesters must hold valid and operands stable until accepted, and must not make valid depend on ready.
- Round-robin: search starts at (last_grant+1) mod NREQ; reset last_grant = NREQ-1, so requester 0 wins first.
- EXEC: {carry,sum} = op_a + op_b at WIDTH+1 bits, registered into rsp_sum/rsp_carry. Every op, add or accumulate, writes acc[g] <= sum. Go to RESP.
- RESP: rsp_valid=1, with rsp_id/sum/carry held stable until rsp_valid & rsp_ready, then go to IDLE. No new accept in the handshake cycle.
- acc[i] is WIDTH bits per requester, reset 0, and wraps modulo 2^WIDTH. Plain add also overwrites acc[i]; software clears it with a plain add of 0+0.
- ena deasserted in EXEC/RESP: no effect on the current op.
- Reset at any time: the in-flight op is dropped, acc cleared, and no rsp_valid pulse appears.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, busy=0; internal acc=0, last_grant=NREQ-1.
- Accept at cycle T → EXEC at T+1 → rsp_valid high from T+2.
- With rsp_ready held high, the handshake is at T+2, IDLE at T+3, and the next accept is at T+3. Peak throughput is 1 op per 3 cycles.
- Backpressure: RESP is held indefinitely, with outputs stable.
- busy is 1 from T+1 through the handshake cycle.

## Structure
- Package adder_arbiter_pkg holds: state enum (IDLE, EXEC, RESP), default WIDTH/NREQ constants, and an IDW helper function.
- Sub-module rr_arbiter (combinational): inputs valid[NREQ], last_grant; outputs one-hot grant and encoded index. It is reusable for other shared resources.
- The top holds the FSM, operand/result registers and the acc array.

## Test plan
- Reset: hold rst_n=0 with random inputs → all outputs 0. Assert rst_n=0 mid-EXEC → rsp_valid stays 0, and the first later op on req1 in accumulate mode with a=0x05 returns 0x05.
- Single add: req0 a=0x12 b=0x34, rsp_ready=1 → req_ready[0] at T, rsp_valid at T+2, sum=0x46, carry=0, id=0.
- Overflow: req1 a=0xFF b=0x02 → sum=0x01, carry=1, id=1.
- Fairness: req_valid=2'b11 held for 4 ops → grant order 0,1,0,1; ena=0 → no req_ready while valid stays high.
- Accumulate: req1 acc mode a=0x10 three times → sums 0x10, 0x20, 0x30. Then a req0 acc-mode op with a=0x01 → 0x01, showing acc[0] is independent.
- Backpressure: rsp_ready=0 for 5 cycles → rsp_* stable, busy=1, req_ready=0. Release → handshake, next accept one cycle later.
